// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer
//   Controller that sits downstream of the F1 start-light sequencer. It
//   requests a light sequence, waits until every light is lit, holds for a
//   pseudo-random number of ms ticks, then signals lights-out and measures
//   the driver's reaction time in ticks. Pressing the button before
//   lights-out is reported as a false start.
//
// Configuration macro:
//   F1_BTN_SYNC_EN  when defined, the raw button goes through a two-flop
//                   synchronizer before edge detection (press-to-capture
//                   latency 3 clk). When undefined, a single register forms
//                   the edge detector (latency 1 clk).
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   tick          one-cycle enable, one per ms
//   trigger       start request (level), honoured in IDLE/DONE only
//   button        raw driver reaction button
//   lights_in     light pattern from the sequencer (all-ones = all lit)
//   cmd_seq       high in SEQ; AND with tick externally to enable sequencer
//   lights_out    high in TIMING
//   time_ms       measured reaction ticks, held until the next trigger
//   result_valid  one-cycle pulse, reaction (or timeout) captured
//   false_start   one-cycle pulse, button pressed before lights-out
module f1_reaction_timer #(
  parameter int D_WIDTH   = 8,
  parameter int LFSR_W    = 7,
  parameter int CNT_W     = 16,
  parameter int MIN_DELAY = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               trigger,
  input  logic               button,
  input  logic [D_WIDTH-1:0] lights_in,
  output logic               cmd_seq,
  output logic               lights_out,
  output logic [CNT_W-1:0]   time_ms,
  output logic               result_valid,
  output logic               false_start
);

  // The shared delay/reaction counter must also hold LFSR + MIN_DELAY, so it
  // is widened when CNT_W alone is too narrow for the hold delay.
  localparam int CTR_W = (CNT_W > LFSR_W + 1) ? CNT_W : LFSR_W + 1;
  localparam logic [CTR_W-1:0] C_SAT    = CTR_W'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CTR_W-1:0] C_SAT_M1 = C_SAT - CTR_W'(1);
  localparam logic [CTR_W-1:0] C_MIN    = CTR_W'(MIN_DELAY);
  localparam logic [CTR_W-1:0] C_ONE    = CTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEQ, S_HOLD, S_TIMING, S_DONE
  } state_t;

  state_t             r_state, w_state_next;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [CTR_W-1:0]   r_cnt, w_cnt_next;
  logic [CNT_W-1:0]   r_time, w_time_next;
  logic               r_result_valid, w_result_valid_next;
  logic               r_false_start, w_false_start_next;
  logic               r_btn_q;
  logic               w_btn_edge;

`ifdef F1_BTN_SYNC_EN
  logic [1:0] r_btn_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_sync <= 2'b00;
      r_btn_q    <= 1'b0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], button};
      r_btn_q    <= r_btn_sync[1];
    end
  end

  assign w_btn_edge = r_btn_sync[1] & ~r_btn_q;
`else
  always_ff @(posedge clk) begin
    if (rst) r_btn_q <= 1'b0;
    else     r_btn_q <= button;
  end

  assign w_btn_edge = button & ~r_btn_q;
`endif

  // Fibonacci LFSR, x^7 + x^3 + 1, free-running so the sample taken on HOLD
  // entry depends on how long the sequencer took.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_W'(1);
    else     r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_W-1] ^ r_lfsr[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_time         <= '0;
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_time         <= w_time_next;
      r_result_valid <= w_result_valid_next;
      r_false_start  <= w_false_start_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_time_next         = r_time;
    w_result_valid_next = 1'b0;
    w_false_start_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trigger) w_state_next = S_SEQ;
      end
      S_SEQ: begin
        if (w_btn_edge) begin
          w_state_next       = S_DONE;
          w_false_start_next = 1'b1;
          w_time_next        = '0;
        end else if (lights_in == {D_WIDTH{1'b1}}) begin
          w_state_next = S_HOLD;
          w_cnt_next   = CTR_W'(r_lfsr) + C_MIN;
        end
      end
      S_HOLD: begin
        // A press always beats expiry on the same edge.
        if (w_btn_edge) begin
          w_state_next       = S_DONE;
          w_false_start_next = 1'b1;
          w_time_next        = '0;
        end else if (tick) begin
          if (r_cnt == C_ONE) begin
            w_state_next = S_TIMING;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - C_ONE;
          end
        end
      end
      S_TIMING: begin
        if (w_btn_edge) begin
          w_state_next        = S_DONE;
          w_time_next         = r_cnt[CNT_W-1:0];
          w_result_valid_next = 1'b1;
        end else if (tick) begin
          // The tick that brings the counter to all-ones ends the run.
          if (r_cnt >= C_SAT_M1) begin
            w_state_next        = S_DONE;
            w_cnt_next          = C_SAT;
            w_time_next         = '1;
            w_result_valid_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + C_ONE;
          end
        end
      end
      S_DONE: begin
        if (trigger) begin
          w_state_next = S_SEQ;
          w_time_next  = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign cmd_seq      = (r_state == S_SEQ);
  assign lights_out   = (r_state == S_TIMING);
  assign time_ms      = r_time;
  assign result_valid = r_result_valid;
  assign false_start  = r_false_start;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer: default-width instance plus a CNT_W=4
// instance for the saturation timeout. Expected pulses are queued when the
// button or final tick is driven and compared when the pulse appears.
module tb_f1_reaction_timer;

`ifdef F1_BTN_SYNC_EN
  localparam int BTN_LAT = 3;
`else
  localparam int BTN_LAT = 1;
`endif

  typedef struct packed {
    logic        fs;
    logic [15:0] t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        trigger = 1'b0;
  logic        button = 1'b0;
  logic [7:0]  lights_in = 8'h00;
  logic        cmd_seq, lights_out, result_valid, false_start;
  logic [15:0] time_ms;

  logic        trigger4 = 1'b0;
  logic        button4 = 1'b0;
  logic [7:0]  lights4 = 8'h00;
  logic        cmd_seq4, lights_out4, rv4, fs4;
  logic [3:0]  time4;

  logic [6:0]  m_lfsr;
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          seen_pulse;

  f1_reaction_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .button(button),
    .lights_in(lights_in), .cmd_seq(cmd_seq), .lights_out(lights_out),
    .time_ms(time_ms), .result_valid(result_valid), .false_start(false_start)
  );

  f1_reaction_timer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger4), .button(button4),
    .lights_in(lights4), .cmd_seq(cmd_seq4), .lights_out(lights_out4),
    .time_ms(time4), .result_valid(rv4), .false_start(fs4)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^7 + x^3 + 1, seed 1 after reset, shifts every cycle.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 7'h01;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (result_valid || false_start || rv4 || fs4) seen_pulse = 1'b1;
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_once();
  endtask

  task automatic start_run();
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
  endtask

  // Sequencer shows all lights; the hold length is the LFSR value the DUT
  // samples on the coming edge plus MIN_DELAY.
  task automatic enter_hold(output int n);
    n = int'(m_lfsr) + 8;
    lights_in = 8'hFF;
    cyc(1);
    lights_in = 8'h00;
  endtask

  task automatic wait_pulse(output bit got, output bit fs, output bit rv, output logic [15:0] t);
    got = 1'b0; fs = 1'b0; rv = 1'b0; t = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (result_valid || false_start) begin
        got = 1'b1; fs = false_start; rv = result_valid; t = time_ms;
      end
    end
    $display("txn: pulse=%0b false_start=%0b result_valid=%0b time_ms=%0d", got, fs, rv, t);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({cmd_seq, lights_out, result_valid, false_start, time_ms} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0", {cmd_seq, lights_out, result_valid, false_start, time_ms});
    end
    n_vec++;
    if (dut.r_lfsr !== 7'h01) begin
      n_err++;
      $display("FAIL reset_lfsr: got %h, required 01", dut.r_lfsr);
    end
  endtask

  task automatic test_hold_and_reaction();
    int n; bit got, fs, rv; logic [15:0] t; exp_t e;
    seen_pulse = 1'b0;
    start_run();
    n_vec++;
    if (cmd_seq !== 1'b1) begin n_err++; $display("FAIL seq_cmd: got %b, required 1", cmd_seq); end
    enter_hold(n);
    n_vec++;
    if ({cmd_seq, lights_out} !== 2'b00) begin
      n_err++; $display("FAIL hold_entry: cmd_seq/lights_out got %b, required 00", {cmd_seq, lights_out});
    end
    ticks(n - 1);
    n_vec++;
    if (lights_out !== 1'b0) begin n_err++; $display("FAIL hold_early: lights_out got %b after %0d ticks, required 0", lights_out, n - 1); end
    tick_once();
    n_vec++;
    if (lights_out !== 1'b1) begin n_err++; $display("FAIL hold_expiry: lights_out got %b after %0d ticks, required 1", lights_out, n); end
    ticks(5);
    n_vec++;
    if (seen_pulse !== 1'b0) begin n_err++; $display("FAIL stray_pulse: got %b, required 0", seen_pulse); end
    button = 1'b1;
    sb.push_back('{fs: 1'b0, t: 16'd5});
    wait_pulse(got, fs, rv, t);
    button = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if ({got, fs, rv, t} !== {1'b1, e.fs, ~e.fs, e.t}) begin
      n_err++;
      $display("FAIL reaction_5: got pulse=%b fs=%b rv=%b t=%0d, required pulse=1 fs=%b rv=%b t=%0d", got, fs, rv, t, e.fs, ~e.fs, e.t);
    end
    cyc(1);
    n_vec++;
    if ({result_valid, false_start, lights_out, cmd_seq, time_ms} !== {4'b0000, 16'd5}) begin
      n_err++;
      $display("FAIL done_hold: got rv/fs/lo/cs=%b t=%0d, required 0000 t=5", {result_valid, false_start, lights_out, cmd_seq}, time_ms);
    end
  endtask

  task automatic test_false_start();
    int n; bit got, fs, rv; logic [15:0] t; exp_t e;
    start_run();
    lights_in = 8'h07;
    button = 1'b1;
    sb.push_back('{fs: 1'b1, t: 16'd0});
    wait_pulse(got, fs, rv, t);
    button = 1'b0;
    lights_in = 8'h00;
    e = sb.pop_front();
    n_vec++;
    if ({got, fs, rv, t, cmd_seq} !== {1'b1, e.fs, ~e.fs, e.t, 1'b0}) begin
      n_err++;
      $display("FAIL fs_seq: got pulse=%b fs=%b rv=%b t=%0d cmd_seq=%b, required 1 1 0 0 0", got, fs, rv, t, cmd_seq);
    end
    cyc(2);
    start_run();
    enter_hold(n);
    ticks(2);
    button = 1'b1;
    sb.push_back('{fs: 1'b1, t: 16'd0});
    wait_pulse(got, fs, rv, t);
    button = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if ({got, fs, rv, t, cmd_seq} !== {1'b1, e.fs, ~e.fs, e.t, 1'b0}) begin
      n_err++;
      $display("FAIL fs_hold: got pulse=%b fs=%b rv=%b t=%0d cmd_seq=%b, required 1 1 0 0 0", got, fs, rv, t, cmd_seq);
    end
    ticks(n);
    n_vec++;
    if (lights_out !== 1'b0) begin n_err++; $display("FAIL fs_hold_stop: lights_out got %b, required 0", lights_out); end
  endtask

  task automatic test_press_on_expiry();
    int n; exp_t e; logic [17:0] obs;
    cyc(2);
    start_run();
    enter_hold(n);
    // Press so that the detected edge coincides with the final hold tick.
    for (int k = 1; k < n; k++) begin
      if (k == n - (BTN_LAT - 1) / 2) button = 1'b1;
      tick_once();
    end
    tick = 1'b1;
    button = 1'b1;
    sb.push_back('{fs: 1'b1, t: 16'd0});
    @(negedge clk);
    tick = 1'b0;
    obs = {false_start, result_valid, time_ms};
    $display("txn: expiry press false_start=%0b result_valid=%0b time_ms=%0d", obs[17], obs[16], obs[15:0]);
    button = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (obs !== {e.fs, ~e.fs, e.t}) begin
      n_err++;
      $display("FAIL expiry_press: got fs/rv=%b t=%0d, required fs/rv=10 t=0", obs[17:16], obs[15:0]);
    end
    cyc(1);
    n_vec++;
    if (lights_out !== 1'b0) begin n_err++; $display("FAIL expiry_no_lo: lights_out got %b, required 0", lights_out); end
  endtask

  task automatic test_timeout();
    int n; exp_t e; logic [5:0] obs;
    trigger4 = 1'b1;
    cyc(1);
    trigger4 = 1'b0;
    n = int'(m_lfsr) + 8;
    lights4 = 8'hFF;
    cyc(1);
    lights4 = 8'h00;
    ticks(n);
    n_vec++;
    if (lights_out4 !== 1'b1) begin n_err++; $display("FAIL t4_timing: lights_out got %b, required 1", lights_out4); end
    seen_pulse = 1'b0;
    ticks(14);
    n_vec++;
    if ({seen_pulse, lights_out4} !== 2'b01) begin
      n_err++; $display("FAIL t4_early: pulse/lights_out got %b, required 01", {seen_pulse, lights_out4});
    end
    tick = 1'b1;
    sb.push_back('{fs: 1'b0, t: 16'h000F});
    @(negedge clk);
    tick = 1'b0;
    obs = {fs4, rv4, time4};
    $display("txn: timeout false_start=%0b result_valid=%0b time_ms=%0d", obs[5], obs[4], obs[3:0]);
    e = sb.pop_front();
    n_vec++;
    if (obs !== {e.fs, ~e.fs, e.t[3:0]}) begin
      n_err++; $display("FAIL t4_timeout: got fs/rv=%b t=%h, required fs/rv=01 t=F", obs[5:4], obs[3:0]);
    end
    cyc(1);
    n_vec++;
    if ({rv4, lights_out4, time4} !== 6'b00_1111) begin
      n_err++; $display("FAIL t4_done: rv/lo got %b t=%h, required 00 t=F", {rv4, lights_out4}, time4);
    end
  endtask

  task automatic test_retrigger();
    int n; bit got, fs, rv; logic [15:0] t; exp_t e;
    cyc(2);
    start_run();
    enter_hold(n);
    ticks(n + 3);
    button = 1'b1;
    sb.push_back('{fs: 1'b0, t: 16'd3});
    wait_pulse(got, fs, rv, t);
    button = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if ({got, fs, rv, t} !== {1'b1, e.fs, ~e.fs, e.t}) begin
      n_err++; $display("FAIL reaction_3: got pulse=%b fs=%b rv=%b t=%0d, required 1 0 1 3", got, fs, rv, t);
    end
    cyc(1);
    start_run();
    n_vec++;
    if ({cmd_seq, time_ms} !== {1'b1, 16'd0}) begin
      n_err++; $display("FAIL retrigger_done: cmd_seq got %b t=%0d, required 1 t=0", cmd_seq, time_ms);
    end
    enter_hold(n);
    ticks(2);
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    n_vec++;
    if ({cmd_seq, lights_out} !== 2'b00) begin
      n_err++; $display("FAIL trigger_in_hold: cmd_seq/lights_out got %b, required 00", {cmd_seq, lights_out});
    end
    ticks(n - 3);
    n_vec++;
    if (lights_out !== 1'b0) begin n_err++; $display("FAIL hold_kept_early: lights_out got %b, required 0", lights_out); end
    tick_once();
    n_vec++;
    if (lights_out !== 1'b1) begin n_err++; $display("FAIL hold_kept_expiry: lights_out got %b, required 1", lights_out); end
  endtask

  task automatic test_reset_mid_timing();
    ticks(2);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    n_vec++;
    if ({cmd_seq, lights_out, result_valid, false_start, time_ms} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h, required 0", {cmd_seq, lights_out, result_valid, false_start, time_ms});
    end
    n_vec++;
    if (dut.r_lfsr !== 7'h01) begin n_err++; $display("FAIL reset_mid_lfsr: got %h, required 01", dut.r_lfsr); end
    ticks(3);
    start_run();
    n_vec++;
    if (cmd_seq !== 1'b1) begin n_err++; $display("FAIL reset_idle_trigger: cmd_seq got %b, required 1", cmd_seq); end
  endtask

  initial begin
    test_reset();
    test_hold_and_reaction();
    test_false_start();
    test_press_on_expiry();
    test_timeout();
    test_retrigger();
    test_reset_mid_timing();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
